// File: rtl/hack_instr_fetch.sv
// Hack CPU instruction fetch unit: tagged one-entry buffer in front of a req/ack instruction ROM.
// Define HACK_FETCH_PREFETCH_EN to add a second entry that prefetches pc+1.
module hack_instr_fetch #(
    parameter int ADDR_W  = 15,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        pc,
    input  logic               fetch_en,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               rom_req,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic               rom_ack,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [15:0]        miss_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic                 v0_q, v0_d;
    logic [ADDR_W-1:0]    tag0_q, tag0_d;
    logic [INSTR_W-1:0]   data0_q, data0_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic                 rom_req_q, rom_req_d;
    logic [15:0]          miss_count_q, miss_count_d;

    logic [ADDR_W-1:0]    pc_addr;
    logic                 hit0;
    logic                 hit;
    logic                 pc_hi_unused;

    // PC bits above the ROM address width never select anything.
    assign pc_addr      = pc[ADDR_W-1:0];
    assign pc_hi_unused = ^pc[15:ADDR_W];
    assign hit0         = v0_q && (tag0_q == pc_addr);

`ifdef HACK_FETCH_PREFETCH_EN
    logic                 v1_q, v1_d;
    logic [ADDR_W-1:0]    tag1_q, tag1_d;
    logic [INSTR_W-1:0]   data1_q, data1_d;
    logic                 fill_e1_q, fill_e1_d;
    logic                 hit1;
    logic                 fill_to_e0;
    logic [ADDR_W-1:0]    next_addr;

    assign hit1        = v1_q && (tag1_q == pc_addr);
    assign hit         = hit0 || hit1;
    assign next_addr   = tag0_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign fill_to_e0  = (state_q == BUSY) && rom_ack && !fill_e1_q;
    // E1-only hits are served through the bypass until the promotion edge.
    assign instr       = (hit1 && !hit0) ? data1_q : data0_q;
`else
    assign hit         = hit0;
    assign instr       = data0_q;
`endif

    assign instr_valid = fetch_en && hit;
    assign rom_req     = rom_req_q;
    assign rom_addr    = req_addr_q;
    assign miss_count  = miss_count_q;

    always_comb begin
        state_d      = state_q;
        v0_d         = v0_q;
        tag0_d       = tag0_q;
        data0_d      = data0_q;
        req_addr_d   = req_addr_q;
        rom_req_d    = rom_req_q;
        miss_count_d = miss_count_q;
`ifdef HACK_FETCH_PREFETCH_EN
        v1_d         = v1_q;
        tag1_d       = tag1_q;
        data1_d      = data1_q;
        fill_e1_d    = fill_e1_q;

        // A demand fill into E0 on the same edge takes priority over promotion.
        if (hit1 && !hit0 && !fill_to_e0) begin
            v0_d    = 1'b1;
            tag0_d  = tag1_q;
            data0_d = data1_q;
            v1_d    = 1'b0;
        end
`endif

        case (state_q)
            IDLE: begin
                rom_req_d = 1'b0;
                if (fetch_en && !hit) begin
                    state_d    = BUSY;
                    rom_req_d  = 1'b1;
                    req_addr_d = pc_addr;
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
`ifdef HACK_FETCH_PREFETCH_EN
                    fill_e1_d  = 1'b0;
                end else if (fetch_en && hit0 && !(v1_q && (tag1_q == next_addr))) begin
                    state_d    = BUSY;
                    rom_req_d  = 1'b1;
                    req_addr_d = next_addr;
                    fill_e1_d  = 1'b1;
`endif
                end
            end
            BUSY: begin
                if (rom_ack) begin
                    state_d   = IDLE;
                    rom_req_d = 1'b0;
`ifdef HACK_FETCH_PREFETCH_EN
                    if (fill_e1_q) begin
                        v1_d    = 1'b1;
                        tag1_d  = req_addr_q;
                        data1_d = rom_data;
                    end else begin
                        v0_d    = 1'b1;
                        tag0_d  = req_addr_q;
                        data0_d = rom_data;
                    end
`else
                    v0_d    = 1'b1;
                    tag0_d  = req_addr_q;
                    data0_d = rom_data;
`endif
                end
            end
            default: begin
                state_d   = IDLE;
                rom_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            v0_q         <= 1'b0;
            tag0_q       <= '0;
            data0_q      <= '0;
            req_addr_q   <= '0;
            rom_req_q    <= 1'b0;
            miss_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            v0_q         <= v0_d;
            tag0_q       <= tag0_d;
            data0_q      <= data0_d;
            req_addr_q   <= req_addr_d;
            rom_req_q    <= rom_req_d;
            miss_count_q <= miss_count_d;
        end
    end

`ifdef HACK_FETCH_PREFETCH_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q      <= 1'b0;
            tag1_q    <= '0;
            data1_q   <= '0;
            fill_e1_q <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            tag1_q    <= tag1_d;
            data1_q   <= data1_d;
            fill_e1_q <= fill_e1_d;
        end
    end
`endif

endmodule
